nn_seq_ctrl: RTL and testbench

Inference sequencer for the fully-connected accelerator.
- On a CPU start command it takes ownership of the 46 weight SRAMs, the bias SRAM and the image SRAM.
- It sweeps a shared read address over all inputs and sequences the 46 MAC lanes through clear, accumulate, bias-add and result-latch.
- It then returns SRAM ownership to the CPU interface and flags completion.
- It sits between the CPU register decode and the SRAM/MAC datapath; SRAM_OWN drives the SRAM address/write muxes.

---
 rtl/nn_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_nn_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_seq_ctrl.sv
// rtl/nn_seq_ctrl.sv - inference sequencer: SRAM ownership, address sweep and MAC lane control.
// Optional cycle counter on CYC_CNT is built when NN_SEQ_PERF_CNT_EN is defined.
`timescale 1ns/1ps

module nn_seq_ctrl #(
    parameter int N_IN     = 784,
    parameter int ADR_W    = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic             CLK,
    input  logic             RESET_X,
    input  logic             START,
    input  logic             ABORT,
    input  logic             DONE_CLR,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             SRAM_OWN,
    output logic             RD_EN,
    output logic [ADR_W-1:0] RD_ADR,
    output logic             MAC_CLR,
    output logic             MAC_EN,
    output logic             BIAS_EN,
    output logic             RESULT_LATCH,
    output logic [31:0]      CYC_CNT
);

    localparam int               CNT_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADR_W-1:0] LAST_ADR   = ADR_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_DRAIN,
        ST_BIAS,
        ST_LATCH
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [CNT_W-1:0]    drain_q;
    logic [CNT_W-1:0]    drain_n;
    logic [ADR_W-1:0]    rd_adr_q;
    logic [ADR_W-1:0]    adr_n;
    logic [PIPE_LAT-1:0] mac_pipe_q;

    logic busy_q;
    logic own_q;
    logic rd_en_q;
    logic mac_clr_q;
    logic bias_en_q;
    logic latch_q;
    logic done_q;
    logic err_q;

    logic abort_hit;
    logic start_acc;
    logic start_err;
    logic done_set;
    logic done_n;
    logic err_n;

    assign abort_hit = ABORT && (state_q != ST_IDLE);
    assign start_acc = START && (state_q == ST_IDLE);
    assign start_err = START && (state_q != ST_IDLE);
    assign done_set  = (state_q == ST_LATCH) && !ABORT;

    always_comb begin
        state_n = state_q;
        drain_n = drain_q;
        adr_n   = rd_adr_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_n = ST_CLR;
                end
            end
            ST_CLR: begin
                state_n = ST_RUN;
            end
            ST_RUN: begin
                if (rd_adr_q == LAST_ADR) begin
                    state_n = ST_DRAIN;
                    drain_n = DRAIN_LOAD;
                end else begin
                    adr_n = rd_adr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_n = ST_BIAS;
                end else begin
                    drain_n = drain_q - 1'b1;
                end
            end
            ST_BIAS: begin
                state_n = ST_LATCH;
            end
            ST_LATCH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_n = ST_IDLE;
        end
        // Address parks at zero outside the sweep and holds the last word through drain.
        if ((state_n == ST_IDLE) || (state_n == ST_CLR)) begin
            adr_n = '0;
        end
    end

    always_comb begin
        done_n = done_q;
        err_n  = err_q;
        if (done_set) begin
            done_n = 1'b1;
        end else if (start_acc || DONE_CLR) begin
            done_n = 1'b0;
        end
        if (start_err) begin
            err_n = 1'b1;
        end else if (start_acc || DONE_CLR) begin
            err_n = 1'b0;
        end
    end

    // Output flops load the decode of the next state so each output matches the state register.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            rd_adr_q   <= '0;
            mac_pipe_q <= '0;
            busy_q     <= 1'b0;
            own_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            mac_clr_q  <= 1'b0;
            bias_en_q  <= 1'b0;
            latch_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            drain_q    <= drain_n;
            rd_adr_q   <= adr_n;
            busy_q     <= (state_n != ST_IDLE);
            own_q      <= (state_n != ST_IDLE);
            rd_en_q    <= (state_n == ST_RUN);
            mac_clr_q  <= (state_n == ST_CLR);
            bias_en_q  <= (state_n == ST_BIAS);
            latch_q    <= (state_n == ST_LATCH);
            done_q     <= done_n;
            err_q      <= err_n;
            mac_pipe_q <= abort_hit ? '0 : ((mac_pipe_q << 1) | PIPE_LAT'(rd_en_q));
        end
    end

    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign SRAM_OWN     = own_q;
    assign RD_EN        = rd_en_q;
    assign RD_ADR       = rd_adr_q;
    assign MAC_CLR      = mac_clr_q;
    assign MAC_EN       = mac_pipe_q[PIPE_LAT-1];
    assign BIAS_EN      = bias_en_q;
    assign RESULT_LATCH = latch_q;

`ifdef NN_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            CYC_CNT <= 32'h0000_0000;
        end else if (start_acc) begin
            CYC_CNT <= 32'h0000_0000;
        end else if (busy_q && (CYC_CNT != 32'hFFFF_FFFF)) begin
            CYC_CNT <= CYC_CNT + 32'd1;
        end
    end
`else
    assign CYC_CNT = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// tb/tb_nn_seq_ctrl.sv - scoreboard bench for nn_seq_ctrl against a phase-based reference model.
`timescale 1ns/1ps

module tb_nn_seq_ctrl;

    localparam int N_IN     = 4;
    localparam int ADR_W    = 3;
    localparam int PIPE_LAT = 2;
    localparam int LAST_K   = N_IN + PIPE_LAT + 2;
    localparam int VW       = ADR_W + 41;

    logic             CLK = 1'b0;
    logic             RESET_X = 1'b0;
    logic             START = 1'b0;
    logic             ABORT = 1'b0;
    logic             DONE_CLR = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic             SRAM_OWN;
    logic             RD_EN;
    logic [ADR_W-1:0] RD_ADR;
    logic             MAC_CLR;
    logic             MAC_EN;
    logic             BIAS_EN;
    logic             RESULT_LATCH;
    logic [31:0]      CYC_CNT;

    nn_seq_ctrl #(.N_IN(N_IN), .ADR_W(ADR_W), .PIPE_LAT(PIPE_LAT)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .START(START), .ABORT(ABORT), .DONE_CLR(DONE_CLR),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .SRAM_OWN(SRAM_OWN), .RD_EN(RD_EN),
        .RD_ADR(RD_ADR), .MAC_CLR(MAC_CLR), .MAC_EN(MAC_EN), .BIAS_EN(BIAS_EN),
        .RESULT_LATCH(RESULT_LATCH), .CYC_CNT(CYC_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    bit mon_en = 1'b0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] act_vec;

    assign act_vec = {BUSY, DONE, ERR, SRAM_OWN, RD_EN, RD_ADR,
                      MAC_CLR, MAC_EN, BIAS_EN, RESULT_LATCH, CYC_CNT};

    // Reference model: a sequence is a phase count k since the clear cycle.
    bit          m_active;
    int          m_k;
    bit          m_done;
    bit          m_err;
    logic [31:0] m_cyc;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] exp_now();
        bit               run;
        int               adr;
        logic [ADR_W-1:0] adr_v;
        logic [31:0]      cyc;
        run = m_active && (m_k >= 1) && (m_k <= N_IN);
        if (run)
            adr = m_k - 1;
        else if (m_active && (m_k > N_IN))
            adr = N_IN - 1;
        else
            adr = 0;
        adr_v = adr[ADR_W-1:0];
`ifdef NN_SEQ_PERF_CNT_EN
        cyc = m_cyc;
`else
        cyc = 32'h0;
`endif
        return {m_active, m_done, m_err, m_active, run, adr_v,
                m_active && (m_k == 0),
                m_active && (m_k >= PIPE_LAT + 1) && (m_k <= PIPE_LAT + N_IN),
                m_active && (m_k == N_IN + PIPE_LAT + 1),
                m_active && (m_k == LAST_K),
                cyc};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_cyc    = 32'h0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit c);
        bit acc;
        bit serr;
        bit dset;
        acc  = s && !m_active;
        serr = s && m_active;
        dset = 1'b0;
        if (acc)
            m_cyc = 32'h0;
        else if (m_active && (m_cyc != 32'hFFFF_FFFF))
            m_cyc = m_cyc + 32'd1;
        if (m_active) begin
            if (a) begin
                m_active = 1'b0;
            end else if (m_k == LAST_K) begin
                m_active = 1'b0;
                dset     = 1'b1;
            end else begin
                m_k = m_k + 1;
            end
        end else if (s) begin
            m_active = 1'b1;
            m_k      = 0;
        end
        if (dset)
            m_done = 1'b1;
        else if (acc || c)
            m_done = 1'b0;
        if (serr)
            m_err = 1'b1;
        else if (acc || c)
            m_err = 1'b0;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input bit s, input bit a, input bit c);
        START    = s;
        ABORT    = a;
        DONE_CLR = c;
        model_step(s, a, c);
        exp_q.push_back(exp_now());
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        START    = 1'b0;
        ABORT    = 1'b0;
        DONE_CLR = 1'b0;
        RESET_X  = 1'b0;
        #1;
        check("async_reset", act_vec, '0);
        model_reset();
        exp_q.delete();
        exp_q.push_back(exp_now());
        exp_q.push_back(exp_now());
        @(posedge CLK);
        #1;
        RESET_X = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow cycle %0d: got empty queue expected entry", cyc_no);
            end else begin
                check("outputs", act_vec, exp_q.pop_front());
            end
            cyc_no++;
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", act_vec, '0);
        exp_q.push_back(exp_now());
        mon_en  = 1'b1;
        RESET_X = 1'b1;

        // nominal run
        step(1'b1, 1'b0, 1'b0);
        idle(12);
        // START while busy, then DONE_CLR after completion
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        // ABORT during the sweep
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        idle(10);
        // reset in the middle of drain, then a fresh sequence
        step(1'b1, 1'b0, 1'b0);
        idle(5);
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(12);
        // back-to-back start right when DONE rises
        step(1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 1'b0);
        idle(12);
        // ABORT+START while busy, then ABORT+START in idle
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(12);
        // DONE_CLR on the DONE-setting edge, and with an ERR-setting START
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(7);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) == 0,
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 14) == 0);
            end
        end
        idle(2);
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
